// File: rtl/nibble_rx_pkg.sv
// nibble_rx_pkg: state encoding and parity helper shared by the serial receiver
package nibble_rx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  function automatic logic parity_mismatch(input logic [15:0] d, input logic p, input logic odd);
    return (^d ^ p) != odd;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, resets to the idle-high level
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/nibble_rx.sv
// nibble_rx: serial frame receiver driving a data bus with a one-cycle load strobe
module nibble_rx
  import nibble_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_out,
  output logic              load,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  state_t state, nxt;
  logic rxs, samp, stop_samp, mis;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitc;
  logic [DATA_W-1:0] sh;
  sync2 u_sync (.clk(clk), .reset(reset), .d(rxd), .q(rxs));
  // START samples half a bit in; every later sample is a full bit on, landing mid-bit
  assign samp = cnt == (state == START ? HALF : FULL);
  assign stop_samp = state == STOP && samp;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rxs ? IDLE : START;
      START:   if (samp) nxt = rxs ? IDLE : DATA;
      DATA:    if (samp && bitc == LAST) nxt = PARITY_EN != 0 ? PARITY : STOP;
      PARITY:  if (samp) nxt = STOP;
      STOP:    if (samp) nxt = rxs ? IDLE : BREAK;
      BREAK:   nxt = rxs ? IDLE : BREAK;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      bitc       <= '0;
      sh         <= '0;
      mis        <= 1'b0;
      data_out   <= '0;
      load       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= (state == IDLE || state == BREAK || samp) ? '0 : cnt + 1'b1;
      load       <= stop_samp && rxs && !mis;
      parity_err <= stop_samp && rxs && mis;
      frame_err  <= stop_samp && !rxs;
      if (state == IDLE) begin
        bitc <= '0;
        mis  <= 1'b0;
      end
      if (state == DATA && samp) begin
        sh   <= {rxs, sh[DATA_W-1:1]};
        bitc <= bitc + 1'b1;
      end
      if (state == PARITY && samp) mis <= parity_mismatch(16'(sh), rxs, PARITY_ODD != 0);
      if (stop_samp && rxs && !mis) data_out <= sh;
    end
endmodule
